lsu_ctrl_mo: RTL and testbench

- Next-generation load/store control unit, sitting between the AGU and the DTCM.
- Supports up to OUTS_DEPTH outstanding DTCM transactions and tracks them in an in-order tag FIFO.
- Handles byte, halfword and word accesses: load data is aligned and sign/zero-extended; the write-back result is held in a one-entry output register that honours long-pipe backpressure.
- DTCM response latency is not fixed; any latency of 1 cycle or more is tolerated.

---
 rtl/lsu_ctrl_mo_pkg.sv | 23 ++
 rtl/lsu_tag_fifo.sv | 47 ++++
 rtl/lsu_ctrl_mo.sv | 118 +++++++++++
 tb/tb_lsu_ctrl_mo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_mo_pkg.sv
// lsu_ctrl_mo_pkg: shared widths, access-size encodings and tag-entry layout for the LSU.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 4
`endif
package lsu_ctrl_mo_pkg;
    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam int LSU_TAGE_WIDTH = 7;
    typedef struct packed {
        logic       read;
        logic [1:0] size;
        logic       usign;
        logic [1:0] ofs;
        logic       err;
    } lsu_tage_t;
endpackage

// File: rtl/lsu_tag_fifo.sv
// lsu_tag_fifo: in-order FIFO of outstanding-transaction tags; no same-cycle pass-through.
module lsu_tag_fifo #(
    parameter int DW = 8,
    parameter int DP = 2,
    localparam int PW = DP > 1 ? $clog2(DP) : 1,
    localparam int CW = $clog2(DP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    assign full_o  = count_q == CW'(DP);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    always_comb begin
        wptr_d  = do_push ? (wptr_q == PW'(DP - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d  = do_pop ? (rptr_q == PW'(DP - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end
endmodule

// File: rtl/lsu_ctrl_mo.sv
// lsu_ctrl_mo: AGU-to-DTCM load/store control with in-order outstanding tracking and aligned write-back.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_ctrl_mo
    import lsu_ctrl_mo_pkg::*;
#(
    parameter int XW         = `XLEN,
    parameter int AW         = `DTCM_ADDR_WIDTH,
    parameter int TW         = `ITAG_WIDTH,
    parameter int OUTS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            agu_cmd_valid,
    output logic            agu_cmd_ready,
    input  logic            agu_cmd_read,
    input  logic [AW-1:0]   agu_cmd_addr,
    input  logic [XW-1:0]   agu_cmd_wdata,
    input  logic [XW/8-1:0] agu_cmd_wmask,
    input  logic [1:0]      agu_cmd_size,
    input  logic            agu_cmd_usign,
    input  logic [TW-1:0]   agu_cmd_itag,
    output logic            agu_rsp_valid,
    input  logic            agu_rsp_ready,
    output logic            dtcm_cmd_valid,
    input  logic            dtcm_cmd_ready,
    output logic            dtcm_cmd_read,
    output logic [AW-1:0]   dtcm_cmd_addr,
    output logic [XW-1:0]   dtcm_cmd_wdata,
    output logic [XW/8-1:0] dtcm_cmd_wmask,
    input  logic            dtcm_rsp_valid,
    output logic            dtcm_rsp_ready,
    input  logic [XW-1:0]   dtcm_rsp_rdata,
    output logic            lsu_o_valid,
    input  logic            lsu_o_ready,
    output logic [XW-1:0]   lsu_o_wbck_data,
    output logic [TW-1:0]   lsu_o_wbck_itag,
    output logic            lsu_o_err
);
    localparam int DW = TW + LSU_TAGE_WIDTH;
    localparam int CW = $clog2(OUTS_DEPTH + 1);
    function automatic logic [XW-1:0] lsu_ext(input logic [XW-1:0] rd, input logic [1:0] ofs,
                                              input logic [1:0] size, input logic usign);
        logic [XW-1:0] sh;
        sh = rd >> {ofs, 3'b000};
        return size == LSU_SIZE_B ? {{(XW-8){~usign & sh[7]}}, sh[7:0]} :
               size == LSU_SIZE_H ? {{(XW-16){~usign & sh[15]}}, sh[15:0]} : sh;
    endfunction
    logic          fifo_full, fifo_empty, push, rsp_pop, err_pop, pop, mis, load_en;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_dout;
    logic [TW-1:0] head_itag;
    lsu_tage_t     push_tage, head_tage;
    logic          out_vld_q, out_vld_d, out_err_q, out_err_d;
    logic [XW-1:0] out_data_q, out_data_d;
    logic [TW-1:0] out_itag_q, out_itag_d;
    logic          unused_ok;
`ifdef LSU_MISALIGN_CHK_EN
    // Size 3 falls into the word check alongside size 2.
    assign mis            = agu_cmd_size == LSU_SIZE_H ? agu_cmd_addr[0] : agu_cmd_size[1] & |agu_cmd_addr[1:0];
    assign dtcm_cmd_valid = agu_cmd_valid & ~fifo_full & ~mis;
    assign agu_cmd_ready  = ~fifo_full & (mis | dtcm_cmd_ready);
    assign err_pop        = ~fifo_empty & head_tage.err & ~dtcm_rsp_valid & dtcm_rsp_ready;
`else
    assign mis            = 1'b0;
    assign dtcm_cmd_valid = agu_cmd_valid & ~fifo_full;
    assign agu_cmd_ready  = dtcm_cmd_ready & ~fifo_full;
    assign err_pop        = 1'b0;
`endif
    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_addr  = agu_cmd_addr;
    assign dtcm_cmd_wdata = agu_cmd_wdata;
    assign dtcm_cmd_wmask = agu_cmd_wmask;
    assign push      = agu_cmd_valid & agu_cmd_ready;
    assign push_tage = '{read: agu_cmd_read, size: agu_cmd_size, usign: agu_cmd_usign,
                         ofs: agu_cmd_addr[1:0], err: mis};
    assign {head_itag, head_tage} = fifo_dout;
    assign dtcm_rsp_ready = ~out_vld_q | lsu_o_ready;
    assign rsp_pop        = dtcm_rsp_valid & dtcm_rsp_ready & ~fifo_empty;
    assign pop            = rsp_pop | err_pop;
    assign agu_rsp_valid  = pop;
    assign load_en        = err_pop | (rsp_pop & head_tage.read);
    lsu_tag_fifo #(.DW(DW), .DP(OUTS_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({agu_cmd_itag, push_tage}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    always_comb begin
        out_vld_d  = load_en | (out_vld_q & ~lsu_o_ready);
        out_data_d = load_en ? (err_pop ? '0 : lsu_ext(dtcm_rsp_rdata, head_tage.ofs, head_tage.size, head_tage.usign)) : out_data_q;
        out_itag_d = load_en ? head_itag : out_itag_q;
        out_err_d  = load_en ? err_pop : out_err_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_itag_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_itag_q <= out_itag_d;
            out_err_q  <= out_err_d;
        end
    end
    assign lsu_o_valid     = out_vld_q;
    assign lsu_o_wbck_data = out_vld_q ? out_data_q : '0;
    assign lsu_o_wbck_itag = out_vld_q ? out_itag_q : '0;
    assign lsu_o_err       = out_vld_q & out_err_q;
    assign unused_ok       = &{1'b0, agu_rsp_ready, fifo_count, head_tage.err};
    no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n) !(dtcm_rsp_valid && fifo_empty));
endmodule

// File: tb/tb_lsu_ctrl_mo.sv
// tb_lsu_ctrl_mo: directed vectors with hand-computed results for lsu_ctrl_mo (default 32/16/4, depth 2).
module tb_lsu_ctrl_mo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        agu_cmd_valid = 1'b0, agu_cmd_ready, agu_cmd_read = 1'b0, agu_cmd_usign = 1'b0;
    logic [15:0] agu_cmd_addr = '0;
    logic [31:0] agu_cmd_wdata = '0;
    logic [3:0]  agu_cmd_wmask = '0;
    logic [1:0]  agu_cmd_size = '0;
    logic [3:0]  agu_cmd_itag = '0;
    logic        agu_rsp_valid, agu_rsp_ready = 1'b1;
    logic        dtcm_cmd_valid, dtcm_cmd_ready = 1'b1, dtcm_cmd_read;
    logic [15:0] dtcm_cmd_addr;
    logic [31:0] dtcm_cmd_wdata;
    logic [3:0]  dtcm_cmd_wmask;
    logic        dtcm_rsp_valid = 1'b0, dtcm_rsp_ready;
    logic [31:0] dtcm_rsp_rdata = '0;
    logic        lsu_o_valid, lsu_o_ready = 1'b1, lsu_o_err;
    logic [31:0] lsu_o_wbck_data;
    logic [3:0]  lsu_o_wbck_itag;
    int          n_vec = 0, n_err = 0;
    lsu_ctrl_mo dut (
        .clk(clk), .rst_n(rst_n),
        .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready), .agu_cmd_read(agu_cmd_read),
        .agu_cmd_addr(agu_cmd_addr), .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
        .agu_cmd_size(agu_cmd_size), .agu_cmd_usign(agu_cmd_usign), .agu_cmd_itag(agu_cmd_itag),
        .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
        .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
        .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
        .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready), .lsu_o_wbck_data(lsu_o_wbck_data),
        .lsu_o_wbck_itag(lsu_o_wbck_itag), .lsu_o_err(lsu_o_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #2;
    endtask
    task automatic cmd(input logic rd, input logic [15:0] addr, input logic [1:0] size,
                       input logic usign, input logic [3:0] itag, input logic [31:0] wdata);
        agu_cmd_valid = 1'b1;
        agu_cmd_read  = rd;
        agu_cmd_addr  = addr;
        agu_cmd_size  = size;
        agu_cmd_usign = usign;
        agu_cmd_itag  = itag;
        agu_cmd_wdata = wdata;
        agu_cmd_wmask = 4'hF;
    endtask
    task automatic rsp(input logic v, input logic [31:0] d);
        dtcm_rsp_valid = v;
        dtcm_rsp_rdata = d;
    endtask
    task automatic do_load(input string tag, input logic [15:0] addr, input logic [1:0] size,
                           input logic usign, input logic [3:0] itag, input logic [31:0] rdata,
                           input logic [31:0] exp);
        cmd(1'b1, addr, size, usign, itag, '0);
        settle();
        chk({tag, ".dtcm_v"}, 32'(dtcm_cmd_valid), 32'd1);
        tick();
        agu_cmd_valid = 1'b0;
        rsp(1'b1, rdata);
        settle();
        chk({tag, ".rsp_v"}, 32'(agu_rsp_valid), 32'd1);
        tick();
        rsp(1'b0, '0);
        settle();
        chk({tag, ".o_v"}, 32'(lsu_o_valid), 32'd1);
        chk({tag, ".data"}, lsu_o_wbck_data, exp);
        chk({tag, ".itag"}, 32'(lsu_o_wbck_itag), 32'(itag));
        tick();
    endtask
    initial begin
        #3;
        chk("rst.o_v", 32'(lsu_o_valid), 32'd0);
        chk("rst.rsp_rdy", 32'(dtcm_rsp_ready), 32'd1);
        chk("rst.data", lsu_o_wbck_data, 32'd0);
        chk("rst.err", 32'(lsu_o_err), 32'd0);
        chk("rst.rsp_v", 32'(agu_rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_load("lb", 16'h0103, 2'd0, 1'b0, 4'd5, 32'h80FF_1234, 32'hFFFF_FF80);
        chk("lb.clear", 32'(lsu_o_valid), 32'd0);
        do_load("lhu", 16'h0102, 2'd1, 1'b1, 4'd6, 32'h8001_0000, 32'h0000_8001);
        do_load("lh", 16'h0102, 2'd1, 1'b0, 4'd7, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lbu", 16'h0101, 2'd0, 1'b1, 4'd8, 32'h80FF_1234, 32'h0000_0012);
        do_load("lw", 16'h0100, 2'd2, 1'b0, 4'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("sz3", 16'h0100, 2'd3, 1'b1, 4'd10, 32'h8765_4321, 32'h8765_4321);
        // three back-to-back loads against a depth-2 FIFO
        cmd(1'b1, 16'h0200, 2'd2, 1'b0, 4'd1, '0);
        settle();
        chk("b2b.rdy1", 32'(agu_cmd_ready), 32'd1);
        tick();
        cmd(1'b1, 16'h0204, 2'd2, 1'b0, 4'd2, '0);
        settle();
        chk("b2b.rdy2", 32'(agu_cmd_ready), 32'd1);
        tick();
        cmd(1'b1, 16'h0208, 2'd2, 1'b0, 4'd3, '0);
        settle();
        chk("b2b.full_rdy", 32'(agu_cmd_ready), 32'd0);
        chk("b2b.full_dv", 32'(dtcm_cmd_valid), 32'd0);
        tick();
        rsp(1'b1, 32'h0000_0011);
        settle();
        chk("b2b.full_pop_rdy", 32'(agu_cmd_ready), 32'd0);
        chk("b2b.pop1", 32'(agu_rsp_valid), 32'd1);
        tick();
        rsp(1'b1, 32'h0000_0022);
        settle();
        chk("b2b.rdy3", 32'(agu_cmd_ready), 32'd1);
        chk("b2b.d1", lsu_o_wbck_data, 32'h11);
        chk("b2b.t1", 32'(lsu_o_wbck_itag), 32'd1);
        tick();
        agu_cmd_valid = 1'b0;
        rsp(1'b1, 32'h0000_0033);
        settle();
        chk("b2b.d2", lsu_o_wbck_data, 32'h22);
        chk("b2b.t2", 32'(lsu_o_wbck_itag), 32'd2);
        tick();
        rsp(1'b0, '0);
        settle();
        chk("b2b.d3", lsu_o_wbck_data, 32'h33);
        chk("b2b.t3", 32'(lsu_o_wbck_itag), 32'd3);
        tick();
        chk("b2b.idle", 32'(lsu_o_valid), 32'd0);
        // write-back backpressure with two loads pending
        lsu_o_ready = 1'b0;
        cmd(1'b1, 16'h0300, 2'd2, 1'b0, 4'd6, '0);
        tick();
        cmd(1'b1, 16'h0304, 2'd2, 1'b0, 4'd7, '0);
        rsp(1'b1, 32'h0000_00A1);
        settle();
        chk("bp.rdy0", 32'(dtcm_rsp_ready), 32'd1);
        tick();
        agu_cmd_valid = 1'b0;
        rsp(1'b1, 32'h0000_00B2);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp.stall_rdy", 32'(dtcm_rsp_ready), 32'd0);
            chk("bp.hold", lsu_o_wbck_data, 32'hA1);
            tick();
        end
        lsu_o_ready = 1'b1;
        settle();
        chk("bp.resume_rdy", 32'(dtcm_rsp_ready), 32'd1);
        chk("bp.pop2", 32'(agu_rsp_valid), 32'd1);
        chk("bp.t1", 32'(lsu_o_wbck_itag), 32'd6);
        tick();
        rsp(1'b0, '0);
        settle();
        chk("bp.d2", lsu_o_wbck_data, 32'hB2);
        chk("bp.t2", 32'(lsu_o_wbck_itag), 32'd7);
        tick();
        // store completes without write-back
        cmd(1'b0, 16'h0104, 2'd2, 1'b0, 4'd9, 32'hCAFE_F00D);
        settle();
        chk("sw.wdata", dtcm_cmd_wdata, 32'hCAFE_F00D);
        chk("sw.read", 32'(dtcm_cmd_read), 32'd0);
        tick();
        agu_cmd_valid = 1'b0;
        rsp(1'b1, '0);
        settle();
        chk("sw.rsp_v", 32'(agu_rsp_valid), 32'd1);
        tick();
        rsp(1'b0, '0);
        settle();
        chk("sw.pulse", 32'(agu_rsp_valid), 32'd0);
        chk("sw.no_wb", 32'(lsu_o_valid), 32'd0);
        tick();
        // asynchronous reset with the FIFO full and a result held
        lsu_o_ready = 1'b0;
        cmd(1'b1, 16'h0400, 2'd2, 1'b0, 4'd1, '0);
        tick();
        cmd(1'b1, 16'h0404, 2'd2, 1'b0, 4'd2, '0);
        rsp(1'b1, 32'h5555_AAAA);
        tick();
        cmd(1'b1, 16'h0408, 2'd2, 1'b0, 4'd3, '0);
        rsp(1'b0, '0);
        tick();
        settle();
        chk("rstx.pre_full", 32'(agu_cmd_ready), 32'd0);
        chk("rstx.pre_v", 32'(lsu_o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstx.o_v", 32'(lsu_o_valid), 32'd0);
        chk("rstx.data", lsu_o_wbck_data, 32'd0);
        chk("rstx.itag", 32'(lsu_o_wbck_itag), 32'd0);
        chk("rstx.empty", 32'(agu_cmd_ready), 32'd1);
        chk("rstx.rsp_rdy", 32'(dtcm_rsp_ready), 32'd1);
        agu_cmd_valid = 1'b0;
        lsu_o_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
`ifdef LSU_MISALIGN_CHK_EN
        cmd(1'b1, 16'h0102, 2'd2, 1'b0, 4'd12, '0);
        settle();
        chk("mis.dv", 32'(dtcm_cmd_valid), 32'd0);
        chk("mis.rdy", 32'(agu_cmd_ready), 32'd1);
        tick();
        agu_cmd_valid = 1'b0;
        settle();
        chk("mis.rsp_v", 32'(agu_rsp_valid), 32'd1);
        tick();
        settle();
        chk("mis.o_v", 32'(lsu_o_valid), 32'd1);
        chk("mis.err", 32'(lsu_o_err), 32'd1);
        chk("mis.data", lsu_o_wbck_data, 32'd0);
        chk("mis.itag", 32'(lsu_o_wbck_itag), 32'd12);
        tick();
`else
        cmd(1'b1, 16'h0102, 2'd2, 1'b0, 4'd12, '0);
        settle();
        chk("nochk.dv", 32'(dtcm_cmd_valid), 32'd1);
        tick();
        agu_cmd_valid = 1'b0;
        rsp(1'b1, 32'h1122_3344);
        tick();
        rsp(1'b0, '0);
        settle();
        chk("nochk.data", lsu_o_wbck_data, 32'h0000_1122);
        chk("nochk.err", 32'(lsu_o_err), 32'd0);
        tick();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
